// File: rtl/pkt_ctrl_pkg.sv
// Shared types and helpers for the multi-channel packet framing controller.
package pkt_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PKT  = 2'd1,
    ST_DROP = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    ERR_NONE        = 3'd0,
    ERR_SOP_IN_PKT  = 3'd1,
    ERR_EOP_NO_SOP  = 3'd2,
    ERR_BEAT_NO_SOP = 3'd3,
    ERR_TOO_LONG    = 3'd4,
    ERR_TOO_SHORT   = 3'd5,
    ERR_VAL_GAP     = 3'd6
  } err_code_t;

  // Counters up to 32 bits wide; holds at 2^w-1.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
    logic [31:0] max_v;
    max_v = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    return (v >= max_v) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/pkt_ctrl_ch.sv
// One channel: sop/val/eop framing FSM, length check, error encode and
// saturating statistics.
//   state   | meaning
//   IDLE    | between packets, waiting for sop
//   PKT     | accepting and forwarding beats of an enabled packet
//   DROP    | silently discarding until eop or a new sop
module pkt_ctrl_ch
  import pkt_ctrl_pkg::*;
#(
  parameter int MIN_LEN    = 2,
  parameter int MAX_LEN    = 64,
  parameter int STRICT_VAL = 1,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             val,
  input  logic             sop,
  input  logic             eop,
  input  logic             cfg_port_enable,
  input  logic             cnt_clr,
  output logic             enable,
  output logic             error,
  output logic [2:0]       err_code,
  output logic [CNT_W-1:0] good_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int LEN_W = $clog2(MAX_LEN + 1) + 1;
  localparam logic [LEN_W-1:0] MAX_L = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] MIN_L = LEN_W'(MIN_LEN);

  state_t           state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d, len_inc;
  logic             enable_q, enable_d;
  logic             error_q, error_d;
  err_code_t        code_q, code_d;
  logic [CNT_W-1:0] good_q, good_d, errc_q, errc_d;

  logic      start, fwd, good_inc;
  err_code_t err_v;

  // A valid sop restarts framing from any state.
  assign start   = val & sop;
  assign len_inc = len_q + LEN_W'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      len_q    <= '0;
      enable_q <= 1'b0;
      error_q  <= 1'b0;
      code_q   <= ERR_NONE;
      good_q   <= '0;
      errc_q   <= '0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      enable_q <= enable_d;
      error_q  <= error_d;
      code_q   <= code_d;
      good_q   <= good_d;
      errc_q   <= errc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    if (start) begin
      len_d   = LEN_W'(1);
      state_d = eop ? ST_IDLE : (cfg_port_enable ? ST_PKT : ST_DROP);
    end else begin
      unique case (state_q)
        ST_PKT: begin
          if (val) begin
            if (len_inc > MAX_L) begin
              state_d = ST_DROP;
            end else begin
              len_d = len_inc;
              if (eop) state_d = ST_IDLE;
            end
          end else if (STRICT_VAL != 0) begin
            state_d = ST_DROP;
          end
        end
        ST_DROP: if (val && eop) state_d = ST_IDLE;
        default: state_d = state_q;
      endcase
    end
  end

  // Errors are assigned lowest code first, so later checks only fill an empty slot.
  always_comb begin
    fwd      = 1'b0;
    good_inc = 1'b0;
    err_v    = ERR_NONE;
    if (start) begin
      if (state_q != ST_IDLE) err_v = ERR_SOP_IN_PKT;
      if (cfg_port_enable) begin
        fwd = 1'b1;
        if (eop) begin
          if (MIN_LEN > 1) begin
            if (err_v == ERR_NONE) err_v = ERR_TOO_SHORT;
          end else begin
            good_inc = 1'b1;
          end
        end
      end
    end else begin
      unique case (state_q)
        ST_IDLE: if (val) err_v = eop ? ERR_EOP_NO_SOP : ERR_BEAT_NO_SOP;
        ST_PKT: begin
          if (val) begin
            if (len_inc > MAX_L) begin
              err_v = ERR_TOO_LONG;
            end else begin
              fwd = 1'b1;
              if (eop) begin
                if (len_inc < MIN_L) err_v = ERR_TOO_SHORT;
                else                 good_inc = 1'b1;
              end
            end
          end else if (STRICT_VAL != 0) begin
            err_v = ERR_VAL_GAP;
          end
        end
        default: err_v = ERR_NONE;
      endcase
    end
  end

  always_comb begin
    enable_d = fwd;
    error_d  = (err_v != ERR_NONE);
    code_d   = error_d ? err_v : code_q;
    good_d   = good_q;
    errc_d   = errc_q;
    if (cnt_clr) begin
      good_d = '0;
      errc_d = '0;
    end else begin
      if (good_inc) good_d = CNT_W'(sat_inc(32'(good_q), CNT_W));
      if (error_d)  errc_d = CNT_W'(sat_inc(32'(errc_q), CNT_W));
    end
  end

  assign enable   = enable_q;
  assign error    = error_q;
  assign err_code = code_q;
  assign good_cnt = good_q;
  assign err_cnt  = errc_q;

endmodule

// File: rtl/pkt_ctrl_mc.sv
// NUM_CH independent packet framing channels with packed status vectors.
module pkt_ctrl_mc
  import pkt_ctrl_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int MIN_LEN    = 2,
  parameter int MAX_LEN    = 64,
  parameter int STRICT_VAL = 1,
  parameter int CNT_W      = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_CH-1:0]       val,
  input  logic [NUM_CH-1:0]       sop,
  input  logic [NUM_CH-1:0]       eop,
  input  logic [NUM_CH-1:0]       cfg_port_enable,
  input  logic                    cnt_clr,
  output logic [NUM_CH-1:0]       enable,
  output logic [NUM_CH-1:0]       error,
  output logic [3*NUM_CH-1:0]     err_code,
  output logic [CNT_W*NUM_CH-1:0] good_cnt,
  output logic [CNT_W*NUM_CH-1:0] err_cnt
);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    pkt_ctrl_ch #(
      .MIN_LEN   (MIN_LEN),
      .MAX_LEN   (MAX_LEN),
      .STRICT_VAL(STRICT_VAL),
      .CNT_W     (CNT_W)
    ) u_ch (
      .clk            (clk),
      .reset          (reset),
      .val            (val[g]),
      .sop            (sop[g]),
      .eop            (eop[g]),
      .cfg_port_enable(cfg_port_enable[g]),
      .cnt_clr        (cnt_clr),
      .enable         (enable[g]),
      .error          (error[g]),
      .err_code       (err_code[3*g +: 3]),
      .good_cnt       (good_cnt[CNT_W*g +: CNT_W]),
      .err_cnt        (err_cnt[CNT_W*g +: CNT_W])
    );
  end

endmodule

// File: doc/pkt_ctrl_mc.md
Name: pkt_ctrl_mc

Overview:
Multi-channel, parametrised successor to the single-port packet control FSM. Tracks sop/val/eop framing independently on NUM_CH ports and gates forwarding with a per-port enable that is sampled only at packet start. Detects and encodes framing and length errors, and keeps saturating per-channel good-packet and error counters. Sits between the ingress port adapters and the forwarding datapath; its enable outputs qualify datapath writes.

Parameters:
NUM_CH, 4, number of independent channels
MIN_LEN, 2, minimum legal packet length in beats (1..MAX_LEN)
MAX_LEN, 64, maximum legal packet length in beats
STRICT_VAL, 1, 1 = val deassertion inside a packet is an error; 0 = gaps allowed
CNT_W, 16, width of the statistics counters

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
val  in  NUM_CH  beat valid per channel
sop  in  NUM_CH  start of packet, qualified by val
eop  in  NUM_CH  end of packet, qualified by val
cfg_port_enable  in  NUM_CH  per-channel forwarding enable
cnt_clr  in  1  synchronous clear of all counters
enable  out  NUM_CH  registered; beat forwarded (1-cycle latency)
error  out  NUM_CH  registered 1-cycle pulse on error detection
err_code  out  3*NUM_CH  code of last error, held until next error
good_cnt  out  CNT_W*NUM_CH  good packets received, saturating
err_cnt  out  CNT_W*NUM_CH  errors detected, saturating

Behaviour:
- Reset: every channel goes to IDLE; enable, error, err_code, good_cnt, err_cnt, and the length counter all = 0. Reset during a packet discards it, with no error and no count.
- sop and eop are ignored when val=0. Channels are fully independent.
- Error codes: 0 NONE, 1 SOP_IN_PKT, 2 EOP_NO_SOP, 3 BEAT_NO_SOP, 4 TOO_LONG, 5 TOO_SHORT, 6 VAL_GAP.
- At most one error per channel per cycle. When several conditions are true, the lowest code wins.
- On an error: error pulses in cycle N+1, err_code updates, err_cnt increments.
- Per-channel states: IDLE, PKT (accepting), DROP (discarding).
- IDLE transitions:
  - val&sop: cfg_port_enable is sampled now; len=1.
  - If enabled and eop (single-beat packet): emit the beat. If MIN_LEN>1, raise TOO_SHORT; otherwise good_cnt++. Stay IDLE.
  - If enabled and not eop: go to PKT.
  - If disabled: go to DROP silently, or stay IDLE if eop.
  - val&!sop&eop: EOP_NO_SOP. val&!sop&!eop: BEAT_NO_SOP. Stay IDLE in both cases.
- PKT transitions:
  - val&sop: SOP_IN_PKT. The old packet is abandoned without counting; the new sop is processed exactly as in IDLE.
  - val&!sop: len++.
  - New len > MAX_LEN: TOO_LONG; the beat is not forwarded; go to DROP.
  - eop with len ≤ MAX_LEN: beat forwarded. len < MIN_LEN gives TOO_SHORT; otherwise good_cnt++. Go to IDLE.
  - !val with STRICT_VAL=1: VAL_GAP, go to DROP. With STRICT_VAL=0, hold state.
- DROP transitions:
  - Beats are silently discarded; val&eop goes to IDLE.
  - val&sop: SOP_IN_PKT, then processed as in IDLE.
  - No further errors other than SOP_IN_PKT are raised in DROP.
- enable[i]=1 in cycle N+1 for every beat forwarded in cycle N.
- cfg_port_enable changes mid-packet have no effect until the next sop.
- len width is clog2(MAX_LEN+1)+1, so len never wraps before the TOO_LONG check.
- Counters:
  - Saturate at 2^CNT_W-1.
  - cnt_clr wins over a same-cycle increment (result 0).
  - err_code is not cleared by cnt_clr.

Decomposition:
- Package pkt_ctrl_pkg holds:
  - the state enum (IDLE, PKT, DROP);
  - the err_code_t 3-bit enum with the constants above;
  - a saturating-increment function.
- Sub-module pkt_ctrl_ch implements one channel (FSM, length counter, counters).
- pkt_ctrl_mc is a generate loop of NUM_CH instances plus vector packing.

Test Plan:
1. Ch0 enabled, 10-beat packet (sop at beat 1, eop at beat 10) -> enable[0] high for 10 cycles starting one cycle after sop; good_cnt[0]=1; error never pulses.
2. cfg_port_enable[1] drops mid-packet, then the next packet starts with it low -> first packet fully forwarded (good_cnt=1); second packet gives enable=0 for all beats, no error, good_cnt stays 1.
3. Defaults, 65-beat packet on ch2 -> beat 65 not forwarded; error pulse with err_code=4 (TOO_LONG); channel in DROP until eop; next packet accepted normally.
4. Ch3 errors, in order:
   - sop during an open packet -> err_code=1.
   - lone val&eop in IDLE -> err_code=2.
   - val without sop in IDLE -> err_code=3.
   - val gap mid-packet (STRICT_VAL=1) -> err_code=6.
   - err_cnt[3]=4 after the sequence.
5. Single-beat sop&eop packet with MIN_LEN=2 -> err_code=5; good_cnt unchanged. Repeat with MIN_LEN=1 -> good_cnt++.
6. CNT_W=2, five good packets -> good_cnt saturates at 3. Assert cnt_clr in the same cycle as an increment -> counter reads 0. Assert reset mid-packet -> all outputs 0, no error pulse.
